// File: rtl/operand_skew_feeder_pkg.sv
// Shared torus-array types: feeder FSM states and default edge geometry.
// Optional build macro used by the feeder: SKEW_FEEDER_STALL_CNT_EN.
package torus_pkg;

    localparam int DEF_OPERAND_WIDTH = 8;
    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_skew_feeder_if.sv
// Upstream handshake plus PE-edge outputs of the operand skew feeder.
// master = upstream/array side, slave = feeder.
interface operand_skew_feeder_if
    import torus_pkg::*;
#(
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int N = DEF_N
);

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [N*OPERAND_WIDTH-1:0] in_data_i;
    logic                       in_last_i;
    logic                       array_stall_i;
    logic [N*OPERAND_WIDTH-1:0] lane_data_o;
    logic [N-1:0]               lane_valid_o;
    logic                       array_en_o;
    logic                       done_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, array_stall_i,
        input  in_ready_o, lane_data_o, lane_valid_o,
        input  array_en_o, done_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, array_stall_i,
        output in_ready_o, lane_data_o, lane_valid_o,
        output array_en_o, done_o
    );

endinterface

// File: rtl/operand_skew_feeder_skew_delay_line.sv
// Enable-gated shift register of DEPTH stages; one per skewed lane.
module skew_delay_line
    import torus_pkg::*;
#(
    parameter int WIDTH = DEF_OPERAND_WIDTH + 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (en_i) begin
            r_stage[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Diagonal-skew operand feeder for one torus array edge, with tile drain.
// Define SKEW_FEEDER_STALL_CNT_EN to add the stall_cnt_o counter port.
module operand_skew_feeder
    import torus_pkg::*;
#(
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int N = DEF_N
) (
    input  logic clk_i,
    input  logic reset,
    operand_skew_feeder_if.slave bus
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int CW = cnt_width(N);
    localparam bit MULTI = (N > 1);

    feeder_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_ready;
    logic          w_accept;
    logic          w_adv;

    assign w_ready  = !reset && !bus.array_stall_i && (r_state != DRAIN);
    assign w_accept = bus.in_valid_i && w_ready;
    assign w_adv    = w_accept || (r_state == DRAIN && !bus.array_stall_i);

    assign bus.in_ready_o = w_ready;
    assign bus.array_en_o = w_adv;
    assign bus.done_o     = r_done;

    // Non-accepting advances push zero/invalid fill into every lane.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [OPERAND_WIDTH:0] w_d;
        logic [OPERAND_WIDTH:0] w_q;

        assign w_d = w_accept
            ? {1'b1, bus.in_data_i[gi*OPERAND_WIDTH +: OPERAND_WIDTH]}
            : '0;

        skew_delay_line #(
            .WIDTH (OPERAND_WIDTH + 1),
            .DEPTH (gi + 1)
        ) u_dl (
            .clk_i (clk_i),
            .reset (reset),
            .en_i  (w_adv),
            .d_i   (w_d),
            .q_o   (w_q)
        );

        assign bus.lane_data_o[gi*OPERAND_WIDTH +: OPERAND_WIDTH] =
            w_q[OPERAND_WIDTH-1:0];
        assign bus.lane_valid_o[gi] = w_q[OPERAND_WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, STREAM: begin
                    if (w_accept) begin
                        if (!bus.in_last_i) begin
                            r_state <= STREAM;
                        end else if (MULTI) begin
                            r_state <= DRAIN;
                            r_cnt   <= CW'(N - 1);
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.array_stall_i) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.array_stall_i && r_state != IDLE &&
                     r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
